// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: K-ROM prefetch, load, 64 rounds, H update.
// Optional: SHA256_ROM_PREFETCH_EN folds the ROM prime read into LOAD.
module sha256_round_ctrl #(
  parameter int ROUNDS   = 64,
  parameter int BLKCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                first_blk,
  input  logic                abort,
  output logic                ready,
  output logic                busy,
  output logic                rom_rd,
  output logic [5:0]          rom_addr,
  output logic                ld_en,
  output logic                iv_sel,
  output logic                round_en,
  output logic [5:0]          round_idx,
  output logic                w_sel,
  output logic                upd_en,
  output logic                done,
  output logic [BLKCNT_W-1:0] blk_cnt
);

  if (ROUNDS != 64) begin : g_bad_rounds
    $error("sha256_round_ctrl: ROUNDS must be 64");
  end

`ifdef SHA256_ROM_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);
  localparam logic [5:0] W_EXP = 6'd16;
  localparam logic [BLKCNT_W-1:0] ONE = BLKCNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRIME,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  state_t     state;
  state_t     nstate;
  logic [5:0] t;
  logic [5:0] nt;
  logic       take;

  assign take = (state == S_IDLE) && start && !abort;

  // Next state / round counter; abort beats everything once busy.
  always_comb begin
    nstate = state;
    nt     = t;
    if (state != S_IDLE && abort) begin
      nstate = S_IDLE;
      nt     = '0;
    end else begin
      unique case (state)
        S_IDLE:  if (take) nstate = S_LOAD;
        S_LOAD:  nstate = PREFETCH ? S_ROUND : S_PRIME;
        S_PRIME: nstate = S_ROUND;
        S_ROUND: begin
          if (t == LAST) begin
            nstate = S_FINAL;
            nt     = '0;
          end else begin
            nt = t + 6'd1;
          end
        end
        S_FINAL: nstate = S_DONE;
        S_DONE:  nstate = S_IDLE;
        default: begin
          nstate = S_IDLE;
          nt     = '0;
        end
      endcase
    end
  end

  // State, counters and outputs registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      t         <= '0;
      iv_sel    <= 1'b0;
      blk_cnt   <= '0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      rom_rd    <= 1'b0;
      rom_addr  <= '0;
      ld_en     <= 1'b0;
      round_en  <= 1'b0;
      round_idx <= '0;
      w_sel     <= 1'b0;
      upd_en    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= nstate;
      t     <= nt;
      if (take) iv_sel <= first_blk;
      if (nstate == S_DONE)
        blk_cnt <= iv_sel ? ONE : blk_cnt + ONE;
      ready  <= (nstate == S_IDLE);
      busy   <= (nstate != S_IDLE);
      ld_en  <= (nstate == S_LOAD);
      rom_rd <= (nstate == S_LOAD && PREFETCH)
             || (nstate == S_PRIME)
             || (nstate == S_ROUND && nt != LAST);
      rom_addr  <= (nstate == S_ROUND) ? nt + 6'd1 : 6'd0;
      round_en  <= (nstate == S_ROUND);
      round_idx <= nt;
      w_sel     <= (nstate == S_ROUND) && (nt >= W_EXP);
      upd_en    <= (nstate == S_FINAL);
      done      <= (nstate == S_DONE);
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Scoreboard bench for sha256_round_ctrl with a K-ROM model.
// Random block stream with abort, reset and busy-start events.
module tb_sha256_round_ctrl;

`ifdef SHA256_ROM_PREFETCH_EN
  localparam int LAT = 67;
  localparam int OFF = 2;
`else
  localparam int LAT = 68;
  localparam int OFF = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, first_blk, abort;
  logic        ready, busy, rom_rd, ld_en, iv_sel;
  logic        round_en, w_sel, upd_en, done;
  logic [5:0]  rom_addr, round_idx;
  logic [15:0] blk_cnt;

  sha256_round_ctrl #(.ROUNDS(64), .BLKCNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .first_blk(first_blk), .abort(abort),
    .ready(ready), .busy(busy), .rom_rd(rom_rd),
    .rom_addr(rom_addr), .ld_en(ld_en), .iv_sel(iv_sel),
    .round_en(round_en), .round_idx(round_idx),
    .w_sel(w_sel), .upd_en(upd_en), .done(done),
    .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    int          c0;
    logic [15:0] cnt;
    logic        iv;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ld_exp = -1;
  logic [15:0] mcnt = '0;

  logic        kv = 1'b0;
  logic [5:0]  ka = '0;
  logic [31:0] k = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered ROM: data for an address appears one cycle after the read.
  always @(posedge clk) begin
    kv <= rom_rd;
    ka <= rom_addr;
    k  <= KT[rom_addr];
  end

  task automatic chk(string nm, logic [31:0] a,
                     logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)",
               nm, a, e, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rom_rd", rom_rd, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_ld_en", ld_en, 0);
    chk("rst_iv_sel", iv_sel, 0);
    chk("rst_round_en", round_en, 0);
    chk("rst_round_idx", round_idx, 0);
    chk("rst_w_sel", w_sel, 0);
    chk("rst_upd_en", upd_en, 0);
    chk("rst_done", done, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
  endtask

  // Monitor: compares every cycle against the scoreboard front.
  initial begin
    int  rnd;
    bit  eu, ed;
    rnd = 0;
    forever begin
      @(negedge clk);
      chk("ready_busy", busy, {31'd0, !ready});
      chk("ld_en", ld_en, {31'd0, cyc == ld_exp});
      if (ld_en) rnd = 0;
      if (rom_rd)
        chk("rom_rd_scope", ready | upd_en | done, 0);
      if (round_en) begin
        chk("round_idx", round_idx, rnd);
        chk("w_sel", w_sel, {31'd0, rnd >= 16});
        chk("rom_rd_last", rom_rd, {31'd0, rnd < 63});
        if (rom_rd) chk("rom_addr", rom_addr, rnd + 1);
        chk("k_valid", kv, 1);
        chk("k_addr", ka, round_idx);
        chk("k_value", k, KT[rnd & 63]);
        rnd++;
      end
      while (q.size() > 0 && cyc > q[0].c0 + LAT) begin
        chk("done_missing", 0, 1);
        void'(q.pop_front());
      end
      eu = q.size() > 0 && cyc == q[0].c0 + LAT - 1;
      ed = q.size() > 0 && cyc == q[0].c0 + LAT;
      chk("upd_en", upd_en, {31'd0, eu});
      chk("done", done, {31'd0, ed});
      if (ed) begin
        chk("blk_cnt", blk_cnt, q[0].cnt);
        chk("iv_sel", iv_sel, q[0].iv);
        void'(q.pop_front());
      end
    end
  end

  // mode 0 normal, 1 abort@t30, 2 reset@t40, 3 start@t10
  task automatic do_block(bit first, int mode);
    int w, c0;
    w = 0;
    while (!ready && w < 300) begin
      tick();
      w++;
    end
    if (!ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    start = 1'b1;
    first_blk = first;
    c0 = cyc;
    ld_exp = c0 + 1;
    if (mode == 0 || mode == 3) begin
      mcnt = first ? 16'd1 : mcnt + 16'd1;
      q.push_back('{c0: c0, cnt: mcnt, iv: first});
    end
    tick();
    start = 1'b0;
    first_blk = 1'($urandom_range(0, 1));
    chk("ld_iv_sel", iv_sel, {31'd0, first});
    if (mode == 3) begin
      while (cyc < c0 + OFF + 10) tick();
      chk("busy_t10", busy, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
    end else if (mode == 1) begin
      while (cyc < c0 + OFF + 30) tick();
      chk("abort_t", round_idx, 30);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_ready", ready, 1);
      chk("abort_round_en", round_en, 0);
      chk("abort_rom_rd", rom_rd, 0);
    end else if (mode == 2) begin
      while (cyc < c0 + OFF + 40) tick();
      chk("reset_t", round_idx, 40);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      mcnt = '0;
      chk_reset();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, m, sel;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    first_blk = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk_reset();
    tick();

    do_block(1'b1, 0);
    do_block(1'b0, 3);
    do_block(1'b0, 1);
    do_block(1'b0, 0);
    do_block(1'b1, 2);

    w = 0;
    while (!ready && w < 300) begin
      tick();
      w++;
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_ready", ready, 1);
    chk("sa_busy", busy, 0);
    chk("sa_ld_en", ld_en, 0);

    do_block(1'b1, 0);
    do_block(1'b0, 0);
    do_block(1'b0, 0);

    for (int i = 0; i < 16; i++) begin
      sel = $urandom_range(0, 9);
      m = (sel < 6) ? 0 : (sel < 8) ? 3 : (sel == 8) ? 1 : 2;
      do_block($urandom_range(0, 3) == 0, m);
      repeat ($urandom_range(0, 3)) tick();
    end

    w = 0;
    while (q.size() > 0 && w < 300) begin
      tick();
      w++;
    end
    chk("drain", q.size(), 0);
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
